// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the 4-digit scan controller: control/data in, decoder nibble and anodes out.
// The master drives enable/value/load/blank_lz. The slave (the scan controller) drives the display outputs.
interface seg7_scan_ctrl_if;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bin;
    logic [3:0]  anode;
    logic        load_ack;
    logic        frame_done;

    modport master (
        output enable, value, load, blank_lz,
        input  bin, anode, load_ack, frame_done
    );

    modport slave (
        input  enable, value, load, blank_lz,
        output bin, anode, load_ack, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-seg scanner with dead-time blanking, leading-zero suppression and tear-free value commit.
// All outputs are registered; new values are committed only at the frame boundary; load is always accepted.
module seg7_scan_ctrl #(
    parameter int ON_CYCLES   = 4,
    parameter int DEAD_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    seg7_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        frame_end;
    logic        commit;

    logic [3:0]  anode_q, anode_d;
    logic [3:0]  bin_q, bin_d;
    logic        load_ack_q, load_ack_d;
    logic        frame_done_q, frame_done_d;
    logic        suppress;

    // State and output registers; outputs are precomputed from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_vld_q   <= 1'b0;
            anode_q      <= 4'b1111;
            bin_q        <= 4'h0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            anode_q      <= anode_d;
            bin_q        <= bin_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: slot sequencing plus the pending/display value pipeline
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;

        if (!bus.enable) begin
            state_d = ST_OFF;
            digit_d = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        state_d   = ST_BLANK;
                        cnt_d     = '0;
                        digit_d   = digit_q + 2'd1;
                        frame_end = (digit_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load landing on the commit edge stays pending for the next frame
        commit     = frame_end && pend_vld_q;
        disp_d     = commit ? pend_q : disp_q;
        pend_d     = bus.load ? bus.value : pend_q;
        pend_vld_d = bus.load ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
    end

    // Output decode from the next state, so every display output comes straight from a flop
    always_comb begin
        suppress = 1'b0;
        if (bus.blank_lz) begin
            case (digit_d)
                2'd1:    suppress = (disp_d[15:4]  == 12'h000);
                2'd2:    suppress = (disp_d[15:8]  == 8'h00);
                2'd3:    suppress = (disp_d[15:12] == 4'h0);
                default: suppress = 1'b0;
            endcase
        end

        anode_d = 4'b1111;
        if (state_d == ST_SHOW && !suppress) begin
            anode_d[digit_d] = 1'b0;
        end

        bin_d        = disp_d[{digit_d, 2'b00} +: 4];
        load_ack_d   = commit;
        frame_done_d = frame_end;
    end

    assign bus.anode      = anode_q;
    assign bus.bin        = bin_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at default timing (5-clock slots, 20-clock frames).
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.ON_CYCLES(4), .DEAD_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected anode at frame position p: slot d = p/5, first clock of each slot is dead time
    function automatic logic [3:0] exp_anode(input int p, input logic [3:0] sup);
        int d;
        logic [3:0] a;
        d = p / 5;
        a = 4'b1111;
        if ((p % 5) != 0 && !sup[d]) a[d] = 1'b0;
        return a;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    // Starting at frame position 0, step through positions 1..20 of one frame
    task automatic run_frame(input string tag, input logic [3:0] sup, input logic [15:0] shown);
        int p;
        for (int i = 1; i <= 20; i++) begin
            tick();
            p = i % 20;
            chk({tag, ".anode"}, {12'h0, bus.anode}, {12'h0, exp_anode(p, sup)});
            chk({tag, ".frame_done"}, {15'h0, bus.frame_done}, {15'h0, (i == 20)});
            if (i < 20) begin
                chk({tag, ".bin"}, {12'h0, bus.bin}, {12'h0, nib(shown, p / 5)});
                chk({tag, ".load_ack"}, {15'h0, bus.load_ack}, 16'h0);
            end
        end
    endtask

    initial begin
        bus.enable   = 1'b1;
        bus.value    = 16'h0000;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset state
        ticks(2);
        chk("rst.anode", {12'h0, bus.anode}, 16'h000F);
        chk("rst.bin", {12'h0, bus.bin}, 16'h0000);
        chk("rst.load_ack", {15'h0, bus.load_ack}, 16'h0);
        chk("rst.frame_done", {15'h0, bus.frame_done}, 16'h0);

        // First frame after reset: all zeros shown, frame_done at clock 20
        rst = 1'b0;
        chk("f0.anode0", {12'h0, bus.anode}, 16'h000F);
        chk("f0.bin0", {12'h0, bus.bin}, 16'h0000);
        run_frame("f0", 4'b0000, 16'h0000);
        chk("f0.load_ack_end", {15'h0, bus.load_ack}, 16'h0);

        // Mid-frame load of 1234: display must not change before the frame boundary
        ticks(7);
        bus.value = 16'h1234;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("l1234.bin_hold", {12'h0, bus.bin}, 16'h0000);
            chk("l1234.ack_hold", {15'h0, bus.load_ack}, 16'h0);
        end
        tick();
        chk("l1234.load_ack", {15'h0, bus.load_ack}, 16'h1);
        chk("l1234.frame_done", {15'h0, bus.frame_done}, 16'h1);
        chk("l1234.bin_d0", {12'h0, bus.bin}, 16'h0004);
        run_frame("f1234", 4'b0000, 16'h1234);
        chk("f1234.load_ack_end", {15'h0, bus.load_ack}, 16'h0);

        // Two loads in one frame: latest wins, single ack
        ticks(3);
        bus.value = 16'hAAAA;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        ticks(6);
        bus.value = 16'h0005;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        ticks(9);
        chk("l2.load_ack", {15'h0, bus.load_ack}, 16'h1);
        chk("l2.bin_d0", {12'h0, bus.bin}, 16'h0005);
        run_frame("f0005", 4'b0000, 16'h0005);
        chk("f0005.no_second_ack", {15'h0, bus.load_ack}, 16'h0);

        // Leading-zero suppression on 0005: only digit 0 lit, frame period unchanged
        bus.blank_lz = 1'b1;
        run_frame("lz0005", 4'b1110, 16'h0005);
        bus.blank_lz = 1'b0;
        run_frame("nolz0005", 4'b0000, 16'h0005);

        // 0105: an inner zero digit stays lit, only the top zero is suppressed
        bus.value = 16'h0105;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        ticks(19);
        chk("l0105.load_ack", {15'h0, bus.load_ack}, 16'h1);
        bus.blank_lz = 1'b1;
        run_frame("lz0105", 4'b1000, 16'h0105);
        bus.blank_lz = 1'b0;

        // Disable during digit 2 SHOW; a load in OFF is held until the next frame
        ticks(12);
        bus.enable = 1'b0;
        tick();
        chk("off.anode", {12'h0, bus.anode}, 16'h000F);
        chk("off.frame_done", {15'h0, bus.frame_done}, 16'h0);
        bus.value = 16'h00C3;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            chk("off.anode_hold", {12'h0, bus.anode}, 16'h000F);
            chk("off.frame_done_hold", {15'h0, bus.frame_done}, 16'h0);
            chk("off.load_ack_hold", {15'h0, bus.load_ack}, 16'h0);
        end
        bus.enable = 1'b1;
        tick();
        chk("reen.anode", {12'h0, bus.anode}, 16'h000F);
        chk("reen.bin", {12'h0, bus.bin}, 16'h0005);
        run_frame("reen", 4'b0000, 16'h0105);
        chk("reen.load_ack", {15'h0, bus.load_ack}, 16'h1);
        chk("reen.bin_new", {12'h0, bus.bin}, 16'h0003);

        // Async reset mid-frame with a pending load discards it
        ticks(5);
        bus.value = 16'hBEEF;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        ticks(3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.anode", {12'h0, bus.anode}, 16'h000F);
        chk("arst.bin", {12'h0, bus.bin}, 16'h0000);
        chk("arst.load_ack", {15'h0, bus.load_ack}, 16'h0);
        chk("arst.frame_done", {15'h0, bus.frame_done}, 16'h0);
        tick();
        rst = 1'b0;
        chk("post.anode0", {12'h0, bus.anode}, 16'h000F);
        run_frame("post", 4'b0000, 16'h0000);
        chk("post.load_ack", {15'h0, bus.load_ack}, 16'h0);
        chk("post.bin", {12'h0, bus.bin}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
